// File: rtl/sdc_pkg.sv
// Shared constants for the SD command-line engine: response encodings,
// frame lengths, FSM state codes and the CRC7 polynomial.
package sdc_pkg;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_48   = 2'd1;
  localparam logic [1:0] RESP_136  = 2'd2;

  localparam int CMD_LEN     = 48;
  localparam int RESP48_LEN  = 48;
  localparam int RESP136_LEN = 136;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SEND = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_RECV = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  // x^7 + x^3 + 1 with the x^7 term implicit
  localparam logic [6:0] CRC7_POLY = 7'h09;

endpackage

// File: rtl/sdc_crc7.sv
// Bit-serial CRC7 accumulator, one data bit per enabled clock, cleared to zero.
module sdc_crc7
  import sdc_pkg::*;
(
  input  logic       sd_clk,
  input  logic       sd_rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crcReg;
  logic       feedback;

  assign feedback = crcReg[6] ^ din;
  assign crc      = crcReg;

  always_ff @(posedge sd_clk) begin
    if (sd_rst || clr) begin
      crcReg <= '0;
    end else if (en) begin
      crcReg <= {crcReg[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sdc_cmd_engine.sv
// SD CMD-line engine: shifts out a 48-bit command with CRC7, optionally captures
// a 48/136-bit response with timeout/CRC/end/index checks, then drives the NRC gap.
module sdc_cmd_engine
  import sdc_pkg::*;
#(
  parameter int RESP_TIMEOUT = 64,
  parameter int NRC_CYCLES   = 8,
  parameter int TO_BITS      = 7
) (
  input  logic         sd_clk,
  input  logic         sd_rst,
  input  logic         cmd_start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  input  logic         crc_check_en,
  input  logic         cmd_i,
  output logic         cmd_o,
  output logic         cmd_oe,
  output logic         busy,
  output logic         done,
  output logic [127:0] resp,
  output logic [5:0]   resp_index,
  output logic         err_timeout,
  output logic         err_crc,
  output logic         err_end,
  output logic         err_index
);

  logic [2:0]         stateReg;
  logic [7:0]         bitCntReg;
  logic [TO_BITS-1:0] toCntReg;
  logic [47:0]        txShiftReg;
  logic [126:0]       rxShiftReg;
  logic [5:0]         idxReg;
  logic [1:0]         typeReg;
  logic               crcChkReg;
  logic [127:0]       respReg;
  logic [5:0]         respIdxReg;
  logic [3:0]         errReg;  // {timeout, crc, end, index}

  logic [127:0] rxFrame;
  logic [7:0]   lastBit;
  logic         sendActive;

  // Index 0 follows the transmitted frame, index 1 the received response.
  logic       crcClr [2];
  logic       crcEn  [2];
  logic       crcDin [2];
  logic [6:0] crcVal [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_crc
      sdc_crc7 u_crc (
        .sd_clk (sd_clk),
        .sd_rst (sd_rst),
        .clr    (crcClr[gi]),
        .en     (crcEn[gi]),
        .din    (crcDin[gi]),
        .crc    (crcVal[gi])
      );
    end
  endgenerate

  // The TX CRC is fed one bit ahead of the line; the start bit (always 0)
  // leaves a zero CRC unchanged, so it needs no explicit step.
  always_comb begin
    crcClr[0] = (stateReg == ST_IDLE);
    crcEn[0]  = (stateReg == ST_SEND) && (bitCntReg < 8'(CMD_LEN - 9));
    crcDin[0] = txShiftReg[46];
    crcClr[1] = (stateReg == ST_WAIT);
    crcEn[1]  = (stateReg == ST_RECV) && (bitCntReg <= 8'(RESP48_LEN - 9));
    crcDin[1] = cmd_i;
  end

  assign rxFrame    = {rxShiftReg, cmd_i};
  assign lastBit    = (typeReg == RESP_136) ? 8'(RESP136_LEN - 1) : 8'(RESP48_LEN - 1);
  assign sendActive = (stateReg == ST_SEND) && (bitCntReg < 8'(CMD_LEN));

  assign cmd_oe      = sendActive || (stateReg == ST_GAP);
  assign cmd_o       = sendActive ? txShiftReg[47] : 1'b1;
  assign busy        = (stateReg != ST_IDLE);
  assign done        = (stateReg == ST_GAP) && (toCntReg == TO_BITS'(NRC_CYCLES - 1));
  assign resp        = respReg;
  assign resp_index  = respIdxReg;
  assign err_timeout = errReg[3];
  assign err_crc     = errReg[2];
  assign err_end     = errReg[1];
  assign err_index   = errReg[0];

  always_ff @(posedge sd_clk) begin
    if (sd_rst) begin
      stateReg   <= ST_IDLE;
      bitCntReg  <= '0;
      toCntReg   <= '0;
      txShiftReg <= '0;
      rxShiftReg <= '0;
      idxReg     <= '0;
      typeReg    <= RESP_NONE;
      crcChkReg  <= 1'b0;
      respReg    <= '0;
      respIdxReg <= '0;
      errReg     <= '0;
    end else begin
      case (stateReg)
        ST_IDLE: begin
          if (cmd_start) begin
            idxReg     <= cmd_index;
            typeReg    <= (resp_type == RESP_NONE) ? RESP_NONE :
                          (resp_type == RESP_136)  ? RESP_136 : RESP_48;
            crcChkReg  <= crc_check_en;
            errReg     <= '0;
            txShiftReg <= {2'b01, cmd_index, cmd_arg, 8'h01};
            bitCntReg  <= '0;
            stateReg   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (bitCntReg == 8'(CMD_LEN)) begin
            stateReg  <= (typeReg == RESP_NONE) ? ST_GAP : ST_WAIT;
            bitCntReg <= '0;
            toCntReg  <= '0;
          end else begin
            bitCntReg <= bitCntReg + 8'd1;
            // Bit 8 is on the line: splice CRC7 and the end bit in behind it.
            if (bitCntReg == 8'(CMD_LEN - 9))
              txShiftReg <= {crcVal[0], 1'b1, 40'b0};
            else
              txShiftReg <= {txShiftReg[46:0], 1'b0};
          end
        end
        ST_WAIT: begin
          if (!cmd_i) begin
            stateReg   <= ST_RECV;
            bitCntReg  <= 8'd1;
            rxShiftReg <= '0;
          end else if (toCntReg == TO_BITS'(RESP_TIMEOUT - 1)) begin
            errReg[3] <= 1'b1;
            stateReg  <= ST_GAP;
            toCntReg  <= '0;
          end else begin
            toCntReg <= toCntReg + 1'b1;
          end
        end
        ST_RECV: begin
          rxShiftReg <= rxFrame[126:0];
          if (bitCntReg == lastBit) begin
            stateReg  <= ST_GAP;
            bitCntReg <= '0;
            toCntReg  <= '0;
            if (typeReg == RESP_136) begin
              respReg    <= rxFrame;
              respIdxReg <= 6'h3F;
              errReg[1]  <= ~rxFrame[0];
            end else begin
              respReg    <= {96'b0, rxFrame[39:8]};
              respIdxReg <= rxFrame[45:40];
              errReg[2]  <= crcChkReg && (crcVal[1] != rxFrame[7:1]);
              errReg[1]  <= ~rxFrame[0];
              errReg[0]  <= crcChkReg && (rxFrame[45:40] != idxReg);
            end
          end else begin
            bitCntReg <= bitCntReg + 8'd1;
          end
        end
        ST_GAP: begin
          if (toCntReg == TO_BITS'(NRC_CYCLES - 1))
            stateReg <= ST_IDLE;
          else
            toCntReg <= toCntReg + 1'b1;
        end
        default: stateReg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdc_cmd_engine.sv
// Self-checking bench for sdc_cmd_engine: directed scenarios plus randomized
// commands against a frame-level reference model and a simple card model.
module tb_sdc_cmd_engine;

  logic         sd_clk = 1'b0;
  logic         sd_rst;
  logic         cmd_start;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic [1:0]   resp_type;
  logic         crc_check_en;
  logic         cmd_i;
  logic         cmd_o;
  logic         cmd_oe;
  logic         busy;
  logic         done;
  logic [127:0] resp;
  logic [5:0]   resp_index;
  logic         err_timeout;
  logic         err_crc;
  logic         err_end;
  logic         err_index;

  sdc_cmd_engine dut (
    .sd_clk       (sd_clk),
    .sd_rst       (sd_rst),
    .cmd_start    (cmd_start),
    .cmd_index    (cmd_index),
    .cmd_arg      (cmd_arg),
    .resp_type    (resp_type),
    .crc_check_en (crc_check_en),
    .cmd_i        (cmd_i),
    .cmd_o        (cmd_o),
    .cmd_oe       (cmd_oe),
    .busy         (busy),
    .done         (done),
    .resp         (resp),
    .resp_index   (resp_index),
    .err_timeout  (err_timeout),
    .err_crc      (err_crc),
    .err_end      (err_end),
    .err_index    (err_index)
  );

  always #5 sd_clk = ~sd_clk;

  int           nVectors = 0;
  int           nMiscompares = 0;
  int           cyc = 0;
  int           txnNum = 0;
  logic [47:0]  lastTx;
  logic [127:0] expResp = '0;
  logic [5:0]   expIdx = '0;
  logic [3:0]   expErr = '0;

  task automatic checkEq(input string tag, input logic [135:0] got, input logic [135:0] exp);
    nVectors++;
    if (got !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sd_clk);
    #1;
    cyc++;
  endtask

  // CRC7 as the remainder of d(x)*x^7 divided by x^7+x^3+1 (long division).
  function automatic logic [6:0] crc7div(input logic [39:0] d);
    logic [46:0] v;
    v = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    return v[6:0];
  endfunction

  function automatic logic [47:0] frame48(input logic [1:0] top, input logic [5:0] idx,
                                          input logic [31:0] arg);
    logic [39:0] body;
    body = {top, idx, arg};
    return {body, crc7div(body), 1'b1};
  endfunction

  // dly < 0 : card never answers. Otherwise the start bit comes dly cycles after release.
  task automatic runTxn(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                        input logic chkEn, input int dly, input logic [135:0] rframe,
                        input logic startAtDone);
    logic [47:0] txBits;
    logic [47:0] f48;
    int c0, oeMiss, oeN, gapN, doneN, doneRel, expRel, len;
    oeMiss = 0; oeN = 0; gapN = 0; doneN = 0; doneRel = -1;
    len = (rt == 2'd2) ? 136 : 48;

    cmd_index = idx; cmd_arg = arg; resp_type = rt; crc_check_en = chkEn;
    cmd_start = 1'b1;
    c0 = cyc;
    tick();
    cmd_start = 1'b0;
    checkEq("busy_after_start", busy, 1'b1);
    for (int i = 0; i < 48; i++) begin
      txBits[47-i] = cmd_o;
      if (!cmd_oe) oeMiss++;
      // A start while busy, with scrambled inputs, must not disturb anything.
      cmd_start = (i == 10);
      if (i == 10) begin
        cmd_index = 6'($urandom); cmd_arg = $urandom;
        resp_type = 2'($urandom); crc_check_en = 1'($urandom);
      end
      tick();
    end
    cmd_start = 1'b0;
    lastTx = txBits;
    checkEq("tx_frame", txBits, frame48(2'b01, idx, arg));
    checkEq("tx_oe_missing", oeMiss, 0);

    if (rt != 2'd0 && dly >= 0) begin
      for (int i = 0; i < dly + len; i++) begin
        cmd_i = (i < dly) ? 1'b1 : rframe[len-1-(i-dly)];
        if (cmd_oe) oeN++;
        if (done) doneN++;
        tick();
      end
      cmd_i = 1'b1;
    end

    for (int k = 0; k < 250; k++) begin
      if (cmd_oe) oeN++;
      if (cmd_oe && cmd_o) gapN++;
      if (done) begin
        doneN++;
        doneRel = cyc - c0;
        cmd_start = startAtDone;
      end
      if (!busy) break;
      tick();
      cmd_start = 1'b0;
    end
    tick();
    checkEq("idle_after_done", busy, 1'b0);

    if (rt == 2'd0) expRel = 57;
    else if (dly < 0) expRel = 57 + 64;
    else expRel = 56 + dly + len;
    checkEq("done_count", doneN, 1);
    checkEq("done_cycle", doneRel, expRel);
    checkEq("oe_cycles_after_tx", oeN, 8);
    checkEq("gap_high_cycles", gapN, 8);

    if (rt == 2'd0) begin
      expErr = 4'b0000;
    end else if (dly < 0) begin
      expErr = 4'b1000;
    end else if (len == 136) begin
      expResp = rframe[127:0];
      expIdx  = 6'h3F;
      expErr  = {2'b00, ~rframe[0], 1'b0};
    end else begin
      f48     = rframe[47:0];
      expResp = {96'b0, f48[39:8]};
      expIdx  = f48[45:40];
      expErr  = {1'b0, chkEn && (crc7div(f48[47:8]) != f48[7:1]), ~f48[0],
                 chkEn && (f48[45:40] != idx)};
    end
    checkEq("resp", resp, expResp);
    checkEq("resp_index", resp_index, expIdx);
    checkEq("err_flags", {err_timeout, err_crc, err_end, err_index}, expErr);
    $display("txn %0d: CMD%0d arg=%08h type=%0d chk=%0d dly=%0d done@%0d errs=%b",
             txnNum, idx, arg, rt, chkEn, dly, doneRel,
             {err_timeout, err_crc, err_end, err_index});
    txnNum++;
  endtask

  initial begin
    logic [135:0] rf;
    logic [47:0]  f;
    logic [127:0] body;
    logic [5:0]   idx, ri;
    logic [1:0]   rt;
    int           dly, doneN;

    sd_rst = 1'b1; cmd_start = 1'b0; cmd_index = '0; cmd_arg = '0;
    resp_type = '0; crc_check_en = 1'b0; cmd_i = 1'b1;
    repeat (3) tick();
    sd_rst = 1'b0;
    tick();
    checkEq("reset_pins", {cmd_o, cmd_oe, busy, done}, 4'b1000);
    checkEq("reset_resp", {resp, resp_index}, '0);
    checkEq("reset_errs", {err_timeout, err_crc, err_end, err_index}, 4'b0000);

    runTxn(6'd0, 32'h0, 2'd0, 1'b0, 0, '0, 1'b1);
    checkEq("cmd0_wire_frame", lastTx, 48'h400000000095);

    runTxn(6'd8, 32'h1AA, 2'd1, 1'b1, 5, 136'h08000001AA13, 1'b0);
    runTxn(6'd8, 32'h1AA, 2'd1, 1'b1, 5, 136'h08000001AA13 ^ 136'h1000, 1'b0);
    runTxn(6'd8, 32'h1AA, 2'd1, 1'b1, 5, 136'h08000001AA12, 1'b0);
    runTxn(6'd8, 32'h1AA, 2'd1, 1'b1, 5, {88'b0, frame48(2'b00, 6'd55, 32'h1AA)}, 1'b0);
    runTxn(6'd8, 32'h1AA, 2'd1, 1'b1, -1, '0, 1'b0);
    runTxn(6'd8, 32'h1AA, 2'd3, 1'b1, 64, 136'h08000001AA13, 1'b1);
    runTxn(6'd2, 32'h0, 2'd2, 1'b1, 3,
           {2'b00, 6'h3F, 128'h0123456789ABCDEF_FEDCBA9876543211}, 1'b0);

    // Reset in the middle of the command frame.
    cmd_index = 6'd17; cmd_arg = 32'hDEADBEEF; resp_type = 2'd1; crc_check_en = 1'b1;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    repeat (20) tick();
    sd_rst = 1'b1;
    tick();
    sd_rst = 1'b0;
    checkEq("rst_mid_oe", cmd_oe, 1'b0);
    checkEq("rst_mid_busy", busy, 1'b0);
    doneN = 0;
    for (int i = 0; i < 80; i++) begin
      if (done || busy) doneN++;
      tick();
    end
    checkEq("rst_mid_no_activity", doneN, 0);
    expResp = '0; expIdx = '0; expErr = '0;
    checkEq("rst_mid_resp", {resp, resp_index}, '0);
    runTxn(6'd0, 32'h0, 2'd0, 1'b0, 0, '0, 1'b0);
    checkEq("cmd0_after_reset", lastTx, 48'h400000000095);

    for (int n = 0; n < 24; n++) begin
      idx = 6'($urandom);
      rt  = 2'($urandom_range(0, 3));
      dly = ($urandom % 8 == 0) ? -1 : int'($urandom_range(1, 40));
      if (rt == 2'd2) begin
        body = {$urandom, $urandom, $urandom, $urandom};
        body[0] = ($urandom % 4 != 0);
        rf = {2'b00, 6'h3F, body};
      end else begin
        ri = ($urandom % 4 == 0) ? 6'($urandom) : idx;
        f = frame48(2'b00, ri, $urandom);
        if ($urandom % 4 == 0) f[8 + int'($urandom_range(0, 31))] ^= 1'b1;
        if ($urandom % 5 == 0) f[0] = 1'b0;
        rf = {88'b0, f};
      end
      runTxn(idx, $urandom, rt, 1'($urandom), dly, rf, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
